// File: rtl/prefix_sequencer.sv
// rtl/prefix_sequencer.sv - 8086 prefix absorber between prefetch FIFO and microcode dispatch
module prefix_sequencer #(
    parameter int MAX_PREFIXES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic [7:0] fifo_rd_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic [7:0] opcode,
    output logic       opcode_valid,
    input  logic       opcode_ack,
    input  logic       next_instruction,
    output logic       seg_override_valid,
    output logic [1:0] seg_override_sel,
    output logic [1:0] rep_mode,
    output logic       lock,
    output logic [3:0] prefix_count,
    output logic       prefix_overflow
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_OPCODE = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

    state_t state;

    logic is_seg;
    logic is_lock;
    logic is_rep;
    logic is_prefix;
    logic at_max;

    // Decode the FIFO head: 26/2E/36/3E share the 001x_x110 pattern, F2/F3 differ only in bit 0
    always_comb begin
        is_seg    = (fifo_rd_data[7:5] == 3'b001) && (fifo_rd_data[2:0] == 3'b110);
        is_lock   = (fifo_rd_data == 8'hF0);
        is_rep    = (fifo_rd_data[7:1] == 7'b1111_001);
        is_prefix = is_seg || is_lock || is_rep;
        at_max    = (prefix_count == 4'(MAX_PREFIXES));
    end

    // Pop only while collecting bytes; flush and reset suppress the pop in the same cycle
    assign fifo_rd_en = reset_n && (state == S_FETCH) && !fifo_empty && !flush;

    // Sequencer FSM with registered opcode and prefix state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_FETCH;
            opcode             <= 8'h00;
            opcode_valid       <= 1'b0;
            seg_override_valid <= 1'b0;
            seg_override_sel   <= 2'd0;
            rep_mode           <= 2'd0;
            lock               <= 1'b0;
            prefix_count       <= 4'd0;
            prefix_overflow    <= 1'b0;
        end else if (flush) begin
            state              <= S_FETCH;
            opcode_valid       <= 1'b0;
            seg_override_valid <= 1'b0;
            seg_override_sel   <= 2'd0;
            rep_mode           <= 2'd0;
            lock               <= 1'b0;
            prefix_count       <= 4'd0;
            prefix_overflow    <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fifo_rd_en) begin
                        if (is_prefix) begin
                            if (is_seg) begin
                                seg_override_valid <= 1'b1;
                                seg_override_sel   <= fifo_rd_data[4:3];
                            end
                            if (is_lock) begin
                                lock <= 1'b1;
                            end
                            if (is_rep) begin
                                rep_mode <= {1'b1, fifo_rd_data[0]};
                            end
                            // A prefix beyond the limit is still honoured; only the count stops
                            if (at_max) begin
                                prefix_overflow <= 1'b1;
                            end else begin
                                prefix_count <= prefix_count + 4'd1;
                            end
                        end else begin
                            opcode       <= fifo_rd_data;
                            opcode_valid <= 1'b1;
                            state        <= S_OPCODE;
                        end
                    end
                end
                S_OPCODE: begin
                    if (opcode_ack) begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (next_instruction) begin
                        state              <= S_FETCH;
                        opcode_valid       <= 1'b0;
                        seg_override_valid <= 1'b0;
                        seg_override_sel   <= 2'd0;
                        rep_mode           <= 2'd0;
                        lock               <= 1'b0;
                        prefix_count       <= 4'd0;
                        prefix_overflow    <= 1'b0;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prefix_sequencer.sv
// tb/tb_prefix_sequencer.sv - randomized scoreboard bench for prefix_sequencer
module tb_prefix_sequencer;

    localparam int MAXP = 4;

    typedef struct packed {
        logic [7:0] op;
        logic       sv;
        logic [1:0] sel;
        logic [1:0] rep;
        logic       lk;
        logic [3:0] cnt;
        logic       ovf;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       flush = 1'b0;
    logic       opcode_ack = 1'b0;
    logic       next_instruction = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd_en;
    logic [7:0] opcode;
    logic       opcode_valid;
    logic       seg_override_valid;
    logic [1:0] seg_override_sel;
    logic [1:0] rep_mode;
    logic       lock;
    logic [3:0] prefix_count;
    logic       prefix_overflow;

    prefix_sequencer #(.MAX_PREFIXES(MAXP)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .flush              (flush),
        .fifo_rd_data       (fifo_rd_data),
        .fifo_empty         (fifo_empty),
        .fifo_rd_en         (fifo_rd_en),
        .opcode             (opcode),
        .opcode_valid       (opcode_valid),
        .opcode_ack         (opcode_ack),
        .next_instruction   (next_instruction),
        .seg_override_valid (seg_override_valid),
        .seg_override_sel   (seg_override_sel),
        .rep_mode           (rep_mode),
        .lock               (lock),
        .prefix_count       (prefix_count),
        .prefix_overflow    (prefix_overflow)
    );

    always #5 clk = ~clk;

    // Prefetch FIFO model: main process writes, pop process reads
    logic [7:0] fifo_mem [0:1023];
    logic [9:0] wr_ptr = '0;
    logic [9:0] rd_ptr = '0;
    logic       gap = 1'b0;
    logic       rand_gap = 1'b0;
    logic       done = 1'b0;

    assign fifo_empty   = gap || (rd_ptr == wr_ptr);
    assign fifo_rd_data = (rd_ptr == wr_ptr) ? 8'h00 : fifo_mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_rd_en) rd_ptr <= rd_ptr + 10'd1;
    end

    // Scoreboard of expected per-instruction results
    rec_t sb_mem [0:255];
    int   sb_wr = 0;
    int   sb_rd = 0;
    rec_t build = '0;

    logic [7:0] ptab [0:6] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0, 8'hF2, 8'hF3};

    function automatic logic is_pref(input logic [7:0] b);
        case (b)
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0, 8'hF2, 8'hF3: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: accumulate prefixes, push the record when the opcode byte is queued
    task automatic add_byte(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 10'd1;
        if (is_pref(b)) begin
            case (b)
                8'h26: begin build.sv = 1'b1; build.sel = 2'd0; end
                8'h2E: begin build.sv = 1'b1; build.sel = 2'd1; end
                8'h36: begin build.sv = 1'b1; build.sel = 2'd2; end
                8'h3E: begin build.sv = 1'b1; build.sel = 2'd3; end
                8'hF0: build.lk = 1'b1;
                8'hF2: build.rep = 2'd2;
                default: build.rep = 2'd3;
            endcase
            if (int'(build.cnt) == MAXP) build.ovf = 1'b1;
            else build.cnt = build.cnt + 4'd1;
        end else begin
            build.op = b;
            sb_mem[sb_wr[7:0]] = build;
            sb_wr = sb_wr + 1;
            build = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pop(input logic [9:0] target);
        int n;
        n = 0;
        while (rd_ptr != target) begin
            tick();
            n++;
            if (n > 200) begin
                $display("FAIL wait_pop timeout: rd_ptr=%0d required=%0d", rd_ptr, target);
                $fatal(1, "timeout");
            end
        end
    endtask

    // mode 0: next_instruction, 1: flush with next_instruction, 2: reset during EXEC
    task automatic serve(input int ack_dly, input int exec_dly, input int mode);
        int n;
        n = 0;
        while (!opcode_valid) begin
            tick();
            if (rand_gap) gap = ($urandom_range(0, 2) == 0);
            n++;
            if (n > 300) begin
                $display("FAIL opcode_valid timeout: got=0 required=1");
                $fatal(1, "timeout");
            end
        end
        gap = 1'b0;
        repeat (ack_dly) tick();
        opcode_ack = 1'b1;
        next_instruction = rand_gap ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        opcode_ack = 1'b0;
        next_instruction = 1'b0;
        repeat (exec_dly) tick();
        if (mode == 2) begin
            reset_n = 1'b0;
        end else begin
            next_instruction = 1'b1;
            flush = (mode == 1);
            tick();
            next_instruction = 1'b0;
            flush = 1'b0;
        end
    endtask

    // Monitor: cycle-level expectations plus scoreboard pop on each new opcode
    int   total = 0;
    int   bad = 0;
    rec_t cur = '0;
    rec_t got;
    logic m_busy = 1'b0;
    logic m_acked = 1'b0;
    logic m_new = 1'b0;
    logic m_clr = 1'b0;
    logic exp_rden;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        got = {opcode, seg_override_valid, seg_override_sel, rep_mode, lock, prefix_count, prefix_overflow};
        if (done) begin
            check("scoreboard_drained", 32'(sb_rd), 32'(sb_wr));
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end else if (!reset_n) begin
            check("reset_outputs", 32'({got, opcode_valid, fifo_rd_en}), 32'd0);
            m_busy = 1'b0;
            m_acked = 1'b0;
            m_new = 1'b0;
            m_clr = 1'b0;
        end else begin
            exp_rden = !m_busy && !fifo_empty && !flush;
            check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rden));
            check("opcode_valid", 32'(opcode_valid), 32'(m_busy));
            if (m_new) begin
                if (sb_rd >= sb_wr) begin
                    check("unexpected_opcode", 32'(got), 32'd0);
                end else begin
                    cur = sb_mem[sb_rd[7:0]];
                    sb_rd = sb_rd + 1;
                    check("instr_result", 32'(got), 32'(cur));
                end
            end else if (m_busy) begin
                check("held_result", 32'(got), 32'(cur));
            end
            if (m_clr) begin
                check("cleared_prefixes", 32'({got.sv, got.sel, got.rep, got.lk, got.cnt, got.ovf}), 32'd0);
            end
            m_new = 1'b0;
            m_clr = 1'b0;
            if (flush) begin
                m_busy = 1'b0;
                m_acked = 1'b0;
                m_clr = 1'b1;
            end else if (m_busy) begin
                if (m_acked && next_instruction) begin
                    m_busy = 1'b0;
                    m_acked = 1'b0;
                    m_clr = 1'b1;
                end else if (!m_acked && opcode_ack) begin
                    m_acked = 1'b1;
                end
            end else if (exp_rden && !is_pref(fifo_rd_data)) begin
                m_busy = 1'b1;
                m_new = 1'b1;
            end
        end
    end

    // Stimulus
    initial begin
        logic [9:0] t;
        logic [7:0] b;
        int np;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Two segment overrides, last one wins
        add_byte(8'h2E); add_byte(8'h3E); add_byte(8'h8B);
        serve(1, 3, 0);

        // REP followed by a three-cycle FIFO gap
        add_byte(8'hF3);
        t = wr_ptr;
        wait_pop(t);
        gap = 1'b1;
        add_byte(8'hA4);
        repeat (3) tick();
        gap = 1'b0;
        serve(0, 1, 0);

        // Five prefixes against a limit of four
        add_byte(8'hF0); add_byte(8'h26); add_byte(8'hF2);
        add_byte(8'h36); add_byte(8'hF3); add_byte(8'hAC);
        serve(2, 2, 0);

        // Flush right after a segment prefix is popped
        add_byte(8'h26);
        t = wr_ptr;
        build = '0;
        add_byte(8'h90);
        wait_pop(t);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        serve(0, 0, 0);

        // Flush coinciding with next_instruction in EXEC
        add_byte(8'h2E); add_byte(8'hF3); add_byte(8'hA5); add_byte(8'h90);
        serve(1, 2, 1);
        serve(0, 0, 0);

        // Back-pressure with the next instruction waiting in the FIFO
        add_byte(8'h36); add_byte(8'hAD); add_byte(8'h40);
        serve(5, 1, 0);
        serve(0, 0, 0);

        // Reset during EXEC, with bytes waiting in the FIFO
        add_byte(8'h26); add_byte(8'hF2); add_byte(8'hF0); add_byte(8'h4C);
        serve(1, 2, 2);
        add_byte(8'h3E); add_byte(8'hF3); add_byte(8'hA6);
        repeat (2) tick();
        reset_n = 1'b1;
        serve(0, 0, 0);

        // Randomized instructions with random gaps and handshake delays
        rand_gap = 1'b1;
        for (int i = 0; i < 40; i++) begin
            np = $urandom_range(0, 6);
            for (int j = 0; j < np; j++) add_byte(ptab[$urandom_range(0, 6)]);
            b = 8'($urandom_range(0, 255));
            while (is_pref(b)) b = 8'($urandom_range(0, 255));
            add_byte(b);
            serve($urandom_range(0, 3), $urandom_range(0, 3), 0);
        end
        rand_gap = 1'b0;
        gap = 1'b0;

        repeat (3) tick();
        done = 1'b1;
        repeat (5) tick();
        $display("FAIL monitor did not finish");
        $fatal(1, "no finish");
    end

endmodule
